// File: rtl/sqrt_sum_if.sv
// Argument/result bundle for sqrt_sum_pipe: one argument vector in, one reduced root out.
// Valid-only signalling; the consumer cannot stall the producer.
interface sqrt_sum_if #(
  parameter int N_CH = 3,
  parameter int W    = 32
);
  localparam int RW = W/2 + $clog2(N_CH);

  logic              arg_vld;
  logic [N_CH*W-1:0] args;
  logic [N_CH-1:0]   ch_mask;
  logic              mode;
  logic              res_vld;
  logic [RW-1:0]     res;

  modport master (output arg_vld, args, ch_mask, mode, input res_vld, res);
  modport slave  (input arg_vld, args, ch_mask, mode, output res_vld, res);
endinterface

// File: rtl/sqrt_sum_pipe.sv
// N-channel pipelined floor(sqrt) with a masked sum/max reduction.
// W/2 restoring sqrt stages per channel, then one reduce stage: latency W/2+1.
module sqrt_sum_lane #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic [W-1:0]   x,
  output logic [W/2-1:0] root
);
  localparam int H = W/2;

  for (genvar s = 0; s < H; s++) begin : g_st
    localparam int RB = W - 2*s;  // radicand bits not yet consumed on entry to stage s
    logic [H+1:0]  rem_in;
    logic [H-1:0]  root_in;
    logic [H-1:0]  root_r;
    logic [RB-1:0] rad_in;
    logic [H+3:0]  cand;
    logic [H+3:0]  trial;
    logic          ge;

    if (s == 0) begin : g_src
      assign rem_in  = '0;
      assign root_in = '0;
      assign rad_in  = x;
    end else begin : g_src
      assign rem_in  = g_st[s-1].g_carry.rem_r;
      assign root_in = g_st[s-1].root_r;
      assign rad_in  = g_st[s-1].g_carry.rad_r;
    end

    assign cand  = {rem_in, rad_in[RB-1 -: 2]};
    assign trial = {2'b00, root_in, 2'b01};
    assign ge    = cand >= trial;

    always_ff @(posedge clk) root_r <= {root_in[H-2:0], ge};

    // The last stage only needs its root bit; remainder and radicand stop here.
    if (s < H-1) begin : g_carry
      logic [H+1:0]  rem_r;
      logic [H+1:0]  diff;
      logic [RB-3:0] rad_r;
      assign diff = cand[H+1:0] - trial[H+1:0];
      always_ff @(posedge clk) begin
        rem_r <= ge ? diff : cand[H+1:0];
        rad_r <= rad_in[RB-3:0];
      end
    end
  end

  assign root = g_st[H-1].root_r;
endmodule

module sqrt_sum_pipe #(
  parameter int N_CH = 3,
  parameter int W    = 32
) (
  input  logic      clk,
  input  logic      rst,
  sqrt_sum_if.slave bus
);
  localparam int H  = W/2;
  localparam int RW = H + $clog2(N_CH);

  logic [H:0]             vld_pipe;
  logic [H-1:0][N_CH-1:0] mask_q;
  logic [H-1:0]           mode_q;
  logic [N_CH-1:0][H-1:0] roots;
  logic [RW-1:0]          sum;
  logic [H-1:0]           mx;
  logic [RW-1:0]          res_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    sqrt_sum_lane #(.W(W)) u_lane (
      .clk  (clk),
      .x    (bus.args[c*W +: W]),
      .root (roots[c])
    );
  end

  // Mask and mode ride alongside their vector; no reset needed, vld qualifies them.
  always_ff @(posedge clk) begin
    mask_q <= {mask_q[H-2:0], bus.ch_mask};
    mode_q <= {mode_q[H-2:0], bus.mode};
  end

  always_comb begin
    sum = '0;
    mx  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (mask_q[H-1][c]) begin
        sum = sum + RW'(roots[c]);
        if (roots[c] > mx) mx = roots[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      res_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[H-1:0], bus.arg_vld};
      if (vld_pipe[H-1]) res_q <= mode_q[H-1] ? RW'(mx) : sum;
    end
  end

  assign bus.res_vld = vld_pipe[H];
  assign bus.res     = res_q;
endmodule
